// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and constants for the registered mux/arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Operating mode of the channel mux.
  typedef enum logic {
    MUX_SELECT      = 1'b0,
    MUX_ROUND_ROBIN = 1'b1
  } mux_mode_t;

  // Largest channel count the block is intended to be built with.
  localparam int MUX_MAX_CHANNELS = 64;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_arb_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotate-priority pick. Scans requests starting
//                at ptr_i and wrapping modulo CHANNELS; reports the first hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int CHANNELS = 32,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic                grant_valid_o,
  output logic [SEL_W-1:0]    grant_idx_o
);

  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic [SEL_W:0]        w_sum;

  // Rotate requests so ptr_i lands on bit 0, take the lowest set bit, then
  // map the rotated position back to a channel index.
  always_comb begin
    w_dbl         = {req_i, req_i} >> ptr_i;
    w_rot         = w_dbl[CHANNELS-1:0];
    grant_valid_o = 1'b0;
    w_sum         = '0;
    // Descending scan: the last hit written is the lowest rotated position.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        grant_valid_o = 1'b1;
        w_sum         = {1'b0, ptr_i} + (SEL_W+1)'(i);
      end
    end
    if (w_sum >= (SEL_W+1)'(CHANNELS)) begin
      w_sum = w_sum - (SEL_W+1)'(CHANNELS);
    end
    grant_idx_o = w_sum[SEL_W-1:0];
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_reg
//  Description : CHANNELS-to-1 registered mux with valid/ready handshakes.
//                SELECT mode follows an explicit index; ROUND_ROBIN mode
//                arbitrates fairly among valid channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_reg
  import mux_pkg::*;
#(
  parameter  int N        = 32,
  parameter  int CHANNELS = 32,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  mux_mode_t             mode,
  input  logic [SEL_W-1:0]      select,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_chan
);

  // Select can address 2**SEL_W slots; slots beyond CHANNELS read as invalid.
  localparam int               SEL_SPAN  = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic [N-1:0]        out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
  logic [SEL_W-1:0]    rr_ptr_q,    rr_ptr_d;

  logic [SEL_SPAN-1:0] w_valid_ext;
  logic                w_sel_in_range;
  logic                w_rr_valid;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_grant_valid;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_free;
  logic                w_xfer;
  logic [N-1:0]        w_sel_data;

  assign w_valid_ext    = SEL_SPAN'(in_valid);
  assign w_sel_in_range = ({1'b0, select} < (SEL_W+1)'(CHANNELS));
  assign w_free         = !out_valid_q || out_ready;
  assign w_xfer         = w_grant_valid && w_free;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req_i         (in_valid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (w_rr_valid),
    .grant_idx_o   (w_rr_idx)
  );

  // Grant source depends on mode; an out-of-range select never grants.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (mode == MUX_SELECT) begin
      w_grant_valid = w_sel_in_range && w_valid_ext[select];
      w_grant_idx   = select;
    end else begin
      w_grant_valid = w_rr_valid;
      w_grant_idx   = w_rr_idx;
    end
  end

  // Data mux over constant slices, indexed by the granted channel.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant_idx == SEL_W'(k)) begin
        w_sel_data = in_data[k*N +: N];
      end
    end
  end

  // One-hot ready to the granted channel only when the output can accept;
  // held low throughout reset.
  always_comb begin
    in_ready = '0;
    if (w_xfer && rst_n) begin
      in_ready = CHANNELS'(1) << w_grant_idx;
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_free) begin
      out_valid_d = w_xfer;
      if (w_xfer) begin
        out_data_d = w_sel_data;
        out_chan_d = w_grant_idx;
        if (mode == MUX_ROUND_ROBIN) begin
          rr_ptr_d = (w_grant_idx == LAST_CHAN) ? '0 : w_grant_idx + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule : mux_arb_reg
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb_reg
//  Description : Self-checking bench for mux_arb_reg with three builds
//                (32, 4 and 20 channels, 5-bit data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  always #5 clk = ~clk;

  // 32-channel instance
  mux_mode_t    m32;
  logic [4:0]   s32;
  logic [159:0] d32_data;
  logic [31:0]  v32, r32;
  logic [4:0]   o32_data, o32_chan;
  logic         o32_valid, o32_ready;

  // 4-channel instance
  mux_mode_t    m4;
  logic [1:0]   s4;
  logic [19:0]  d4_data;
  logic [3:0]   v4, r4;
  logic [4:0]   o4_data;
  logic [1:0]   o4_chan;
  logic         o4_valid, o4_ready;

  // 20-channel instance
  mux_mode_t    m20;
  logic [4:0]   s20;
  logic [99:0]  d20_data;
  logic [19:0]  v20, r20;
  logic [4:0]   o20_data, o20_chan;
  logic         o20_valid, o20_ready;

  mux_arb_reg #(.N(5), .CHANNELS(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .mode(m32), .select(s32), .in_data(d32_data),
    .in_valid(v32), .in_ready(r32), .out_data(o32_data), .out_valid(o32_valid),
    .out_ready(o32_ready), .out_chan(o32_chan));

  mux_arb_reg #(.N(5), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(m4), .select(s4), .in_data(d4_data),
    .in_valid(v4), .in_ready(r4), .out_data(o4_data), .out_valid(o4_valid),
    .out_ready(o4_ready), .out_chan(o4_chan));

  mux_arb_reg #(.N(5), .CHANNELS(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .mode(m20), .select(s20), .in_data(d20_data),
    .in_valid(v20), .in_ready(r20), .out_data(o20_data), .out_valid(o20_valid),
    .out_ready(o20_ready), .out_chan(o20_chan));

  // Reference grant rule: explicit index, or first valid scanning from ptr.
  function automatic int model_grant(int c, bit rr, int sel, int ptr, logic [63:0] valid);
    if (!rr) return (sel < c && valid[sel]) ? sel : -1;
    for (int i = 0; i < c; i++) begin
      if (valid[(ptr + i) % c]) return (ptr + i) % c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    v32 = '0; v4 = '0; v20 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v32 = '1; v4 = '1; v20 = '1;
    m32 = MUX_SELECT; m4 = MUX_SELECT; m20 = MUX_SELECT;
    s32 = '0; s4 = '0; s20 = '0;
    o32_ready = 1'b1; o4_ready = 1'b1; o20_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o32_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid32: got %0h expected 0", o32_valid); end
    n_cmp++; if (o32_data !== 5'd0) begin n_err++; $display("FAIL reset_data32: got %0h expected 0", o32_data); end
    n_cmp++; if (o32_chan !== 5'd0) begin n_err++; $display("FAIL reset_chan32: got %0h expected 0", o32_chan); end
    n_cmp++; if (r32 !== 32'd0) begin n_err++; $display("FAIL reset_ready32: got %0h expected 0", r32); end
    n_cmp++; if (r4 !== 4'd0) begin n_err++; $display("FAIL reset_ready4: got %0h expected 0", r4); end
    n_cmp++; if (o4_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid4: got %0h expected 0", o4_valid); end
    n_cmp++; if (r20 !== 20'd0) begin n_err++; $display("FAIL reset_ready20: got %0h expected 0", r20); end
    n_cmp++; if (o20_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid20: got %0h expected 0", o20_valid); end
    v32 = '0; v4 = '0; v20 = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_select_sweep();
    for (int k = 0; k < 32; k++) d32_data[k*5 +: 5] = 5'(k);
    v32 = '1; m32 = MUX_SELECT; o32_ready = 1'b1;
    for (int s = 0; s < 32; s++) begin
      s32 = 5'(s);
      #1;
      n_cmp++; if (r32 !== (32'd1 << s)) begin n_err++; $display("FAIL sweep_ready sel=%0d: got %0h expected %0h", s, r32, 32'd1 << s); end
      @(posedge clk); #1;
      n_cmp++; if (o32_data !== 5'(s)) begin n_err++; $display("FAIL sweep_data sel=%0d: got %0h expected %0h", s, o32_data, s); end
      n_cmp++; if (o32_chan !== 5'(s)) begin n_err++; $display("FAIL sweep_chan sel=%0d: got %0h expected %0h", s, o32_chan, s); end
      n_cmp++; if (o32_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid sel=%0d: got %0h expected 1", s, o32_valid); end
    end
    v32 = '0;
  endtask

  task automatic test_rr_fairness();
    d4_data = {5'd11, 5'd10, 5'd9, 5'd8};
    v4 = 4'hF; m4 = MUX_ROUND_ROBIN; o4_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (o4_chan !== 2'(i % 4)) begin n_err++; $display("FAIL rr_chan step=%0d: got %0h expected %0h", i, o4_chan, i % 4); end
      n_cmp++; if (o4_data !== 5'(i % 4 + 8)) begin n_err++; $display("FAIL rr_data step=%0d: got %0h expected %0h", i, o4_data, i % 4 + 8); end
      n_cmp++; if (o4_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid step=%0d: got %0h expected 1", i, o4_valid); end
    end
  endtask

  task automatic test_sparse_wrap();
    int exp_seq[4] = '{3, 1, 3, 1};
    // Pointer is 2 after the fairness run; granting ch2 moves it to 3.
    v4 = 4'b0100;
    @(posedge clk); #1;
    n_cmp++; if (o4_chan !== 2'd2) begin n_err++; $display("FAIL sparse_setup: got %0h expected 2", o4_chan); end
    v4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (o4_chan !== 2'(exp_seq[i])) begin n_err++; $display("FAIL sparse_chan step=%0d: got %0h expected %0h", i, o4_chan, exp_seq[i]); end
    end
    v4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (o4_chan !== 2'd2 || o4_valid !== 1'b1) begin n_err++; $display("FAIL single_chan step=%0d: got chan %0h valid %0h expected chan 2 valid 1", i, o4_chan, o4_valid); end
    end
  endtask

  task automatic test_backpressure();
    d4_data[10 +: 5] = 5'h12;
    m4 = MUX_SELECT; s4 = 2'd2; v4 = 4'hF; o4_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o4_data !== 5'h12 || o4_chan !== 2'd2) begin n_err++; $display("FAIL bp_load: got data %0h chan %0h expected 12 2", o4_data, o4_chan); end
    o4_ready = 1'b0; s4 = 2'd3; m4 = MUX_ROUND_ROBIN;
    #1;
    n_cmp++; if (r4 !== 4'd0) begin n_err++; $display("FAIL bp_ready_now: got %0h expected 0", r4); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (o4_data !== 5'h12) begin n_err++; $display("FAIL bp_data cyc=%0d: got %0h expected 12", i, o4_data); end
      n_cmp++; if (o4_valid !== 1'b1 || o4_chan !== 2'd2) begin n_err++; $display("FAIL bp_hold cyc=%0d: got valid %0h chan %0h expected 1 2", i, o4_valid, o4_chan); end
      n_cmp++; if (r4 !== 4'd0) begin n_err++; $display("FAIL bp_ready cyc=%0d: got %0h expected 0", i, r4); end
    end
    m4 = MUX_SELECT; o4_ready = 1'b1;
    #1;
    n_cmp++; if (r4 !== 4'b1000) begin n_err++; $display("FAIL bp_release_ready: got %0h expected 8", r4); end
    @(posedge clk); #1;
    n_cmp++; if (o4_data !== 5'd11 || o4_chan !== 2'd3 || o4_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_xfer: got data %0h chan %0h valid %0h expected b 3 1", o4_data, o4_chan, o4_valid); end
    v4 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 20; k++) d20_data[k*5 +: 5] = 5'(k);
    m20 = MUX_SELECT; v20 = '1; o20_ready = 1'b1; s20 = 5'd5;
    @(posedge clk); #1;
    n_cmp++; if (o20_valid !== 1'b1 || o20_chan !== 5'd5) begin n_err++; $display("FAIL oor_setup: got valid %0h chan %0h expected 1 5", o20_valid, o20_chan); end
    s20 = 5'd25;
    #1;
    n_cmp++; if (r20 !== 20'd0) begin n_err++; $display("FAIL oor_ready: got %0h expected 0", r20); end
    @(posedge clk); #1;
    n_cmp++; if (o20_valid !== 1'b0) begin n_err++; $display("FAIL oor_valid: got %0h expected 0", o20_valid); end
    n_cmp++; if (o20_chan !== 5'd5 || o20_data !== 5'd5) begin n_err++; $display("FAIL oor_hold: got chan %0h data %0h expected 5 5", o20_chan, o20_data); end
    v20 = '0;
  endtask

  task automatic test_random_c20();
    logic        mv;
    logic [4:0]  md;
    int          mc, mp, g;
    bit          free;
    logic [19:0] exp_r;
    apply_reset();
    mv = 1'b0; md = '0; mc = 0; mp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v20 = 20'($urandom);
      if ($urandom_range(0, 7) == 0) v20 = '0;
      m20 = mux_mode_t'($urandom_range(0, 1));
      s20 = 5'($urandom_range(0, 31));
      o20_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 20; k++) d20_data[k*5 +: 5] = 5'($urandom);
      #1;
      free  = !mv || o20_ready;
      g     = model_grant(20, m20 == MUX_ROUND_ROBIN, int'(s20), mp, 64'(v20));
      exp_r = (g >= 0 && free) ? (20'd1 << g) : 20'd0;
      n_cmp++; if (r20 !== exp_r) begin n_err++; $display("FAIL rand_ready cyc=%0d: got %0h expected %0h", cyc, r20, exp_r); end
      if (free) begin
        if (g >= 0) begin
          mv = 1'b1; md = d20_data[g*5 +: 5]; mc = g;
          if (m20 == MUX_ROUND_ROBIN) mp = (g + 1) % 20;
        end else begin
          mv = 1'b0;
        end
      end
      @(posedge clk); #1;
      n_cmp++; if (o20_valid !== mv || o20_data !== md || o20_chan !== 5'(mc)) begin
        n_err++; $display("FAIL rand_out cyc=%0d: got v%0h d%0h c%0h expected v%0h d%0h c%0h", cyc, o20_valid, o20_data, o20_chan, mv, md, mc);
      end
    end
    v20 = '0;
  endtask

  task automatic test_midop_reset();
    d4_data = {5'd11, 5'd10, 5'd9, 5'd8};
    m4 = MUX_ROUND_ROBIN; v4 = 4'hF; o4_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o4_chan !== 2'd1 || o4_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got chan %0h valid %0h expected 1 1", o4_chan, o4_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o4_valid !== 1'b0 || o4_data !== 5'd0 || o4_chan !== 2'd0) begin n_err++; $display("FAIL midrst_async: got v%0h d%0h c%0h expected 0 0 0", o4_valid, o4_data, o4_chan); end
    n_cmp++; if (r4 !== 4'd0) begin n_err++; $display("FAIL midrst_ready: got %0h expected 0", r4); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o4_chan !== 2'd0 || o4_data !== 5'd8 || o4_valid !== 1'b1) begin n_err++; $display("FAIL midrst_restart: got c%0h d%0h v%0h expected 0 8 1", o4_chan, o4_data, o4_valid); end
    @(posedge clk); #1;
    n_cmp++; if (o4_chan !== 2'd1) begin n_err++; $display("FAIL midrst_next: got %0h expected 1", o4_chan); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    d32_data = '0; d4_data = '0; d20_data = '0;
    test_reset();
    test_select_sweep();
    test_rr_fairness();
    test_sparse_wrap();
    test_backpressure();
    test_out_of_range();
    test_random_c20();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_arb_reg
`default_nettype wire

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised CHANNELS-to-1, N-bit multiplexer with valid/ready handshakes on every input channel and on the output.
- Output is registered.
- Two modes:
  - SELECT: an explicit select port chooses the channel, as a plain mux does.
  - ROUND_ROBIN: the block arbitrates fairly among valid channels.
- Sits between several producers and one shared consumer, e.g. register-file read ports and a shared bus.

Parameters:
- N, 32, data width per channel in bits.
- CHANNELS, 32, number of input channels (2..64; need not be a power of two).
- SEL_W, $clog2(CHANNELS), select/index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = SELECT, 1 = ROUND_ROBIN (mux_pkg::mux_mode_t).
- select  input  SEL_W  channel index used in SELECT mode.
- in_data  input  CHANNELS*N  packed channel data; channel k occupies bits [k*N +: N].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational, at most one bit high (one-hot or zero).
- out_data  output  N  registered selected data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_chan  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
  - in_ready is 0 while in reset.
  - A transfer in flight is discarded; no partial state survives.
- free = !out_valid || out_ready. The output register loads only when free.
- Grant g (combinational):
  - SELECT mode: g=select if select<CHANNELS and in_valid[select]; otherwise no grant.
  - An out-of-range select never grants and never asserts in_ready.
  - ROUND_ROBIN mode: g = first k with in_valid[k], scanning rr_ptr, rr_ptr+1, ... and wrapping modulo CHANNELS. No valid channel means no grant.
- in_ready[g]=free when a grant exists; all other bits are 0. Transfer on channel g when in_valid[g] && in_ready[g].
- On a transfer at edge t:
  - out_data<=in_data[g*N +: N], out_chan<=g, out_valid<=1.
  - In ROUND_ROBIN mode, rr_ptr<=(g+1) mod CHANNELS, wrapping CHANNELS-1 to 0.
- Free with no transfer: out_valid<=0; out_data and out_chan hold their values.
- Output held (out_valid && !out_ready): out_data, out_chan and out_valid are stable, and all in_ready bits are 0.
- Latency is 1 cycle from input handshake to out_valid. Throughput is 1 transfer/cycle with out_ready held high.
  - Simultaneous output pop and input push in the same cycle is a legal back-to-back transfer.
- rr_ptr is updated only in ROUND_ROBIN mode. It is retained across SELECT periods.
  - A mode change takes effect at the next grant evaluation.
  - A mode change never disturbs a held output.
- select and mode are sampled only when free. Their values during a stall are don't-care.
- Fairness: with all channels valid and out_ready=1, each channel is granted exactly once per CHANNELS consecutive transfers.

Decomposition:
- mux_pkg:
  - mux_mode_t enum: MUX_SELECT=1'b0, MUX_ROUND_ROBIN=1'b1.
  - MUX_MAX_CHANNELS=64 constant.
- Sub-module rr_arbiter #(CHANNELS):
  - Inputs: req, ptr.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational rotate-priority pick, instantiated once.
- The top module holds the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset and SELECT sweep (N=5, CHANNELS=32): in_data channel k = k; all valid; mode=0; out_ready=1. Step select 0..31 → one cycle later out_data=select and out_chan=select. in_ready is one-hot at the select index.
- ROUND_ROBIN fairness (CHANNELS=4): all valid; out_ready=1; mode=1 → out_chan sequence is 0,1,2,3,0,1 on consecutive cycles; out_valid stays high.
- Sparse requests and wrap (CHANNELS=4): rr_ptr=3; only ch1 and ch3 valid → grants are 3, 1, 3, 1. Then only ch2 valid → grant 2 every cycle.
- Back-pressure: out_ready=0 for 3 cycles after a load of ch2 data 5'h12 → out_data stays 5'h12, out_valid stays 1, in_ready=0. On release, the next channel transfers in the same cycle.
- Out-of-range select (CHANNELS=20): select=25, all valid → in_ready=0 and out_valid falls to 0 after the next edge.
- Mid-operation reset: assert rst_n=0 asynchronously mid-cycle while out_valid=1 → out_valid, out_data and out_chan read 0 immediately. After release, round robin restarts at channel 0.
